argmax_classifier: RTL and testbench
====================================

# argmax_classifier

Sequential argmax stage placed directly downstream of `dense_layer_4`. Captures the final-layer logit vector on a `start` pulse, scans it one element per cycle with signed comparison, and reports the winning class index and its logit with a one-cycle `result_valid` pulse. Its output is the recognised-word decision consumed by the top-level control/display logic.

## Interface
Parameters:
- `OUT_SIZE`, 3: number of logits/classes; minimum 2.
- `DATA_WIDTH`, 72: logit width, signed; matches the `dense_layer_4` output width.
- `IDX_WIDTH`, `$clog2(OUT_SIZE)`: width of the class index.
- `MARGIN`, 0: unsigned confidence threshold, `DATA_WIDTH+1` bits. Used only when `ARGMAX_MARGIN_CHECK_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `logit_vector`  in  signed [DATA_WIDTH-1:0] [0:OUT_SIZE-1]  logits from `dense_layer_4` `output_vector`. Sampled only on the accepting edge.
- `busy`  out  1  high from the accept edge through the `result_valid` cycle, inclusive.
- `result_valid`  out  1  one-cycle pulse when a result is ready.
- `class_idx`  out  [IDX_WIDTH-1:0]  index of the maximum logit.
- `max_value`  out  signed [DATA_WIDTH-1:0]  value of the maximum logit.
- `low_conf`  out  1  margin flag. Valid with `result_valid`.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - When `start`=1: copy `logit_vector` into an internal register array.
  - Initialise `best`=v[0], `best_idx`=0, `ptr`=1, and set `second` to the most-negative value.
  - Go to SCAN.
- **SCAN**, each cycle:
  - If v[ptr] > `best` (strictly greater, signed): `second`←`best`, `best`←v[ptr], `best_idx`←`ptr`.
  - Else if v[ptr] > `second`: `second`←v[ptr].
  - Then `ptr`++.
  - On the edge that processes `ptr`=OUT_SIZE-1:
    - Register `class_idx` and `max_value` from the updated best.
    - Set `result_valid`=1.
    - Go to DONE.
- **DONE**: lasts one cycle. Clear `result_valid`, go to IDLE.
- Ties: the lowest index wins, as a consequence of the strict greater-than compare.
- `start` while `busy`=1, including the DONE cycle, is ignored and not queued.
- Input changes after the accept edge have no effect on the result in progress.
- `class_idx` and `max_value` hold their last result until the next `result_valid`.
- No arithmetic overflow is possible in the compares. The margin subtraction uses `DATA_WIDTH+1` bits.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `class_idx`=0, `max_value`=0, `low_conf`=0, state IDLE, `ptr`=0.
- `start` sampled high at edge T → `busy`=1 after T.
- SCAN runs on edges T+1 … T+OUT_SIZE-1.
- `result_valid`=1 in the cycle after edge T+OUT_SIZE-1. For OUT_SIZE=3 the latency is 2 edges after accept.
- `busy` falls with `result_valid` at edge T+OUT_SIZE.
- The earliest next accept is at edge T+OUT_SIZE+1 (IDLE), giving a throughput of one vector per OUT_SIZE+1 cycles.
- `rst` asserted in any state, including mid-SCAN:
  - All outputs take their reset values on that edge.
  - The scan in progress is discarded and no `result_valid` is produced.
  - A `start` in the same cycle as `rst` is ignored.

## Configuration
- Macro: `ARGMAX_MARGIN_CHECK_EN`.
- **Defined**:
  - `margin` = `best` − `second`, computed in `DATA_WIDTH+1` bits.
  - `low_conf` = (`margin` < `MARGIN`), registered on the same edge as `result_valid`, held with `class_idx`.
  - Equal top logits give `margin`=0, so `low_conf`=1 whenever `MARGIN`>0.
- **Undefined**:
  - `second` tracking and the subtractor are not built.
  - `low_conf` is tied to 0. The port still exists.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → all outputs 0, no `result_valid`; after release, state IDLE.
- Basic argmax: vector {5, −3, 12}, pulse `start` → exactly 2 edges later `result_valid`=1 for one cycle, `class_idx`=2, `max_value`=12. `busy` high 3 cycles.
- Signed and ties: {−7, −2, −2} → `class_idx`=1, `max_value`=−2. {−1, −1, −1} → `class_idx`=0.
- Busy rejection and input stability:
  - Pulse `start` again 1 cycle after accept, with the input changed to {100, 0, 0} → the first result is unchanged.
  - No second `result_valid` is produced until a `start` is issued in IDLE.
- Reset mid-scan: `rst` on edge T+1 → no `result_valid` ever appears for that request; outputs are 0.
- With `ARGMAX_MARGIN_CHECK_EN` and `MARGIN`=5:
  - {10, 7, 1} → `class_idx`=0, `low_conf`=1.
  - {20, 3, 14} → `class_idx`=0, `low_conf`=0.
  - Without the macro, both cases give `low_conf`=0.

Source files
------------

// File: rtl/argmax_classifier.sv
// argmax_classifier
// Captures a signed logit vector on a start pulse, scans it one element per
// cycle and reports the index and value of the largest logit together with a
// one-cycle result_valid pulse. Ties resolve to the lowest index.
// Optional feature: define ARGMAX_MARGIN_CHECK_EN to track the runner-up logit
// and raise low_conf when (best - second) < MARGIN. Without the macro low_conf
// is tied to 0.
module argmax_classifier #(
    parameter int OUT_SIZE   = 3,
    parameter int DATA_WIDTH = 72,
    parameter int IDX_WIDTH  = $clog2(OUT_SIZE),
    parameter logic [DATA_WIDTH:0] MARGIN = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] logit_vector [0:OUT_SIZE-1],
    output logic                         busy,
    output logic                         result_valid,
    output logic [IDX_WIDTH-1:0]         class_idx,
    output logic signed [DATA_WIDTH-1:0] max_value,
    output logic                         low_conf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUT_SIZE - 1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                  state;
    logic [IDX_WIDTH-1:0]        ptr;
    logic signed [DATA_WIDTH-1:0] vreg [0:OUT_SIZE-1];
    logic signed [DATA_WIDTH-1:0] best;
    logic [IDX_WIDTH-1:0]        best_idx;

    logic signed [DATA_WIDTH-1:0] cur;
    logic signed [DATA_WIDTH-1:0] next_best;
    logic [IDX_WIDTH-1:0]        next_best_idx;
    logic                        next_low_conf;

    logic                        accept;
    assign accept = (state == IDLE) && start;

`ifdef ARGMAX_MARGIN_CHECK_EN
    logic signed [DATA_WIDTH-1:0] second;
    logic signed [DATA_WIDTH-1:0] next_second;
    logic [DATA_WIDTH:0]         margin;

    // Runner-up tracking and confidence margin of the updated best/second pair.
    always_comb begin
        next_second = second;
        if (cur > best) begin
            next_second = best;
        end else if (cur > second) begin
            next_second = cur;
        end
        margin        = {next_best[DATA_WIDTH-1], next_best} - {next_second[DATA_WIDTH-1], next_second};
        next_low_conf = (margin < MARGIN);
    end

    // Runner-up register: seeded with the most negative value on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            second <= MOST_NEG;
        end else if (accept) begin
            second <= MOST_NEG;
        end else if (state == SCAN) begin
            second <= next_second;
        end
    end
`else
    logic unused_margin;
    assign unused_margin = ^MARGIN;
    assign next_low_conf = 1'b0;
`endif

    // One scan step: compare the current element against the running best.
    always_comb begin
        cur           = vreg[ptr];
        next_best     = best;
        next_best_idx = best_idx;
        if (cur > best) begin
            next_best     = cur;
            next_best_idx = ptr;
        end
    end

    // Snapshot of the logit vector so later input changes cannot disturb a scan.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            vreg <= logit_vector;
        end
    end

    // Control FSM plus running best and the registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            best         <= '0;
            best_idx     <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            max_value    <= '0;
            low_conf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        best     <= logit_vector[0];
                        best_idx <= '0;
                        ptr      <= IDX_WIDTH'(1);
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    best     <= next_best;
                    best_idx <= next_best_idx;
                    ptr      <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        class_idx    <= next_best_idx;
                        max_value    <= next_best;
                        low_conf     <= next_low_conf;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed testbench for argmax_classifier (OUT_SIZE=3, DATA_WIDTH=72, MARGIN=5).
// Expected low_conf values follow ARGMAX_MARGIN_CHECK_EN when it is defined.
module tb_argmax_classifier;

    localparam int OUT_SIZE   = 3;
    localparam int DATA_WIDTH = 72;
    localparam int IDX_WIDTH  = 2;

`ifdef ARGMAX_MARGIN_CHECK_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif

    logic                         clk;
    logic                         rst;
    logic                         start;
    logic signed [DATA_WIDTH-1:0] vec [0:OUT_SIZE-1];
    logic                         busy;
    logic                         result_valid;
    logic [IDX_WIDTH-1:0]         class_idx;
    logic signed [DATA_WIDTH-1:0] max_value;
    logic                         low_conf;

    int errors = 0;
    int checks = 0;

    argmax_classifier #(
        .OUT_SIZE   (OUT_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .MARGIN     (73'd5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .logit_vector (vec),
        .busy         (busy),
        .result_valid (result_valid),
        .class_idx    (class_idx),
        .max_value    (max_value),
        .low_conf     (low_conf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic signed [DATA_WIDTH-1:0] got,
                               input logic signed [DATA_WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic signed [DATA_WIDTH-1:0] a,
                                 input logic signed [DATA_WIDTH-1:0] b,
                                 input logic signed [DATA_WIDTH-1:0] c);
        vec[0] = a;
        vec[1] = b;
        vec[2] = c;
        start  = 1'b1;
    endtask

    // Full request: accept, two scan edges, one result cycle, then back to idle.
    task automatic runVector(input string tag,
                             input logic signed [DATA_WIDTH-1:0] a,
                             input logic signed [DATA_WIDTH-1:0] b,
                             input logic signed [DATA_WIDTH-1:0] c,
                             input logic [IDX_WIDTH-1:0] eidx,
                             input logic signed [DATA_WIDTH-1:0] emax,
                             input logic elc);
        applyStimulus(a, b, c);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, ".busy1"}, busy, 1);
        checkOutput({tag, ".rv1"}, result_valid, 0);
        @(negedge clk);
        checkOutput({tag, ".busy2"}, busy, 1);
        checkOutput({tag, ".rv2"}, result_valid, 0);
        @(negedge clk);
        checkOutput({tag, ".busy3"}, busy, 1);
        checkOutput({tag, ".rv3"}, result_valid, 1);
        checkOutput({tag, ".idx"}, class_idx, eidx);
        checkOutput({tag, ".max"}, max_value, emax);
        checkOutput({tag, ".lc"}, low_conf, elc);
        @(negedge clk);
        checkOutput({tag, ".busy4"}, busy, 0);
        checkOutput({tag, ".rv4"}, result_valid, 0);
        checkOutput({tag, ".idxhold"}, class_idx, eidx);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        vec[0] = 72'sd9;
        vec[1] = 72'sd8;
        vec[2] = 72'sd7;

        // Reset held three cycles with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst.busy", busy, 0);
            checkOutput("rst.rv", result_valid, 0);
            checkOutput("rst.idx", class_idx, 0);
            checkOutput("rst.max", max_value, 0);
            checkOutput("rst.lc", low_conf, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("post_rst.busy", busy, 0);
        checkOutput("post_rst.rv", result_valid, 0);

        // Basic and signed/tie cases.
        runVector("basic", 5, -3, 12, 2'd2, 12, 1'b0);
        runVector("signed_tie", -7, -2, -2, 2'd1, -2, MARGIN_ON);
        runVector("all_equal", -1, -1, -1, 2'd0, -1, MARGIN_ON);
        runVector("wide_neg", -72'sd1 <<< 70, 72'sd3, -72'sd4, 2'd1, 3, 1'b0);

        // Busy rejection: new start and input change one cycle after accept.
        applyStimulus(4, 9, 2);
        @(negedge clk);
        applyStimulus(100, 0, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("busyrej.rv", result_valid, 1);
        checkOutput("busyrej.idx", class_idx, 1);
        checkOutput("busyrej.max", max_value, 9);
        checkOutput("busyrej.lc", low_conf, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_start.busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("noqueue.rv", result_valid, 0);
            checkOutput("noqueue.busy", busy, 0);
            checkOutput("noqueue.max", max_value, 9);
        end

        // Reset in the middle of a scan discards the request.
        applyStimulus(50, 60, 70);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst.busy", busy, 0);
        checkOutput("midrst.idx", class_idx, 0);
        checkOutput("midrst.max", max_value, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("midrst.rv", result_valid, 0);
            checkOutput("midrst.max_hold", max_value, 0);
        end

        // Margin cases; low_conf only rises when the margin check is built.
        runVector("margin_low", 10, 7, 1, 2'd0, 10, MARGIN_ON);
        runVector("margin_ok", 20, 3, 14, 2'd0, 20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
